rom_addr_seq: RTL and testbench

ROM_ADDR_SEQ -- requirements
Module: rom_addr_seq

---
 rtl/proc_pkg.sv | 6 +
 rtl/addr_lifo.sv | 30 +++
 rtl/rom_addr_seq.sv | 91 +++++++++
 tb/tb_rom_addr_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared sequencer state encoding and default sizing constants
package proc_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_STACK_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t;
endpackage

// File: rtl/addr_lifo.sv
// addr_lifo: return-address stack with push/pop, top-of-stack read and full/empty flags
module addr_lifo #(
    parameter int W = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    assign full = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign top = empty ? '0 : mem[IW'(cnt - 1'b1)];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (push && !full) cnt <= cnt + 1'b1;
        else if (pop && !empty) cnt <= cnt - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[IW'(cnt)] <= din;
    end
endmodule

// File: rtl/rom_addr_seq.sv
// rom_addr_seq: handshaked ROM address sequencer (IDLE/RUN/HALT); `define ROM_SEQ_CALL_EN adds call/ret return stack
module rom_addr_seq
    import proc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              CP,
    input  logic              RST_n,
    input  logic              en,
    input  logic              wrap,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              addr_ready,
`ifdef ROM_SEQ_CALL_EN
    input  logic              call,
    input  logic              ret,
    output logic              stk_full,
    output logic              stk_err,
`endif
    output logic [ADDR_W-1:0] out_addr_ROM,
    output logic              addr_valid,
    output logic              done
);
    seq_state_t state;
    logic hs, do_push, do_pop, lifo_full, lifo_empty;
    logic [ADDR_W-1:0] lifo_top, next_addr;
    // en=0 drops to IDLE before any handshake can take effect
    assign hs = (state == RUN) && en && addr_ready;
    assign next_addr = out_addr_ROM + 1'b1;
`ifdef ROM_SEQ_CALL_EN
    assign do_push = hs && load && call;
    assign do_pop = hs && !load && ret;
    addr_lifo #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_lifo (
        .clk(CP),
        .rst_n(RST_n),
        .push(do_push),
        .pop(do_pop),
        .din(next_addr),
        .top(lifo_top),
        .full(lifo_full),
        .empty(lifo_empty)
    );
    assign stk_full = lifo_full;
    always_ff @(posedge CP or negedge RST_n) begin
        if (!RST_n) stk_err <= 1'b0;
        else if ((do_push && lifo_full) || (do_pop && lifo_empty)) stk_err <= 1'b1;
    end
`else
    logic unused_cfg;
    assign do_push = 1'b0;
    assign do_pop = 1'b0;
    assign lifo_full = 1'b0;
    assign lifo_empty = 1'b1;
    assign lifo_top = '0;
    assign unused_cfg = ^STACK_DEPTH;
`endif
    always_ff @(posedge CP or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            out_addr_ROM <= RESET_ADDR;
            addr_valid <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            if (!(do_push && lifo_full)) out_addr_ROM <= load_addr;
            state <= en ? RUN : IDLE;
            addr_valid <= en;
            done <= 1'b0;
        end else if (state != HALT) begin
            if (!en) begin
                state <= IDLE;
                addr_valid <= 1'b0;
            end else if (state == IDLE) begin
                state <= RUN;
                addr_valid <= 1'b1;
            end else if (addr_ready) begin
                if (do_pop) begin
                    if (!lifo_empty) out_addr_ROM <= lifo_top;
                end else if (out_addr_ROM == LAST_ADDR && !wrap) begin
                    state <= HALT;
                    addr_valid <= 1'b0;
                    done <= 1'b1;
                end else begin
                    out_addr_ROM <= out_addr_ROM == LAST_ADDR ? RESET_ADDR : next_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_addr_seq.sv
// tb_rom_addr_seq: directed and random checks of rom_addr_seq against a queue-based reference model
module tb_rom_addr_seq;
`ifdef ROM_SEQ_CALL_EN
    localparam bit CALL_EN = 1'b1;
`else
    localparam bit CALL_EN = 1'b0;
`endif
    logic CP = 0, RST_n = 1, en = 0, wrap = 0, load = 0, addr_ready = 0, call = 0, ret = 0;
    logic [3:0] load_addr = 0;
    logic [3:0] out_addr_ROM;
    logic addr_valid, done;
`ifdef ROM_SEQ_CALL_EN
    logic stk_full, stk_err;
`endif
    int n_chk = 0, n_fail = 0;
    int m_st, m_addr;
    bit m_done, m_err;
    int stk[$];

    rom_addr_seq dut (
        .CP(CP),
        .RST_n(RST_n),
        .en(en),
        .wrap(wrap),
        .load(load),
        .load_addr(load_addr),
        .addr_ready(addr_ready),
`ifdef ROM_SEQ_CALL_EN
        .call(call),
        .ret(ret),
        .stk_full(stk_full),
        .stk_err(stk_err),
`endif
        .out_addr_ROM(out_addr_ROM),
        .addr_valid(addr_valid),
        .done(done)
    );

    always #5 CP = ~CP;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".addr"}, 32'(out_addr_ROM), 32'(m_addr));
        chk({tag, ".valid"}, 32'(addr_valid), 32'(m_st == 1));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
`ifdef ROM_SEQ_CALL_EN
        chk({tag, ".full"}, 32'(stk_full), 32'(stk.size() == 4));
        chk({tag, ".err"}, 32'(stk_err), 32'(m_err));
`endif
    endtask

    // reference model: 0=idle 1=run 2=halt, sequence 0..15 with stack as a queue
    task automatic model_edge();
        bit hs = (m_st == 1) && en && addr_ready;
        bit c = CALL_EN && call;
        bit r = CALL_EN && ret;
        if (load) begin
            if (hs && c) begin
                if (stk.size() == 4) m_err = 1;
                else begin
                    stk.push_back((m_addr + 1) % 16);
                    m_addr = load_addr;
                end
            end else m_addr = load_addr;
            m_st = en ? 1 : 0;
            m_done = 0;
        end else if (m_st == 2) begin
        end else if (!en) m_st = 0;
        else if (m_st == 0) m_st = 1;
        else if (addr_ready) begin
            if (r) begin
                if (stk.size() == 0) m_err = 1;
                else m_addr = stk.pop_back();
            end else if (m_addr == 15) begin
                if (wrap) m_addr = 0;
                else begin
                    m_st = 2;
                    m_done = 1;
                end
            end else m_addr = m_addr + 1;
        end
    endtask

    task automatic step(string tag);
        @(posedge CP);
        model_edge();
        @(negedge CP);
        check_all(tag);
    endtask

    task automatic async_reset(string tag);
        #2 RST_n = 0;
        #1;
        m_st = 0;
        m_addr = 0;
        m_done = 0;
        m_err = 0;
        stk.delete();
        check_all(tag);
        @(negedge CP);
        RST_n = 1;
    endtask

    initial begin
        async_reset("reset");
        en = 1; wrap = 1; addr_ready = 1;
        step("start");
        chk("start_valid", 32'(addr_valid), 1);
        for (int i = 0; i < 16; i++) step("wrap_run");
        chk("wrap_to_0", 32'(out_addr_ROM), 0);
        wrap = 0;
        for (int i = 0; i < 16; i++) step("halt_run");
        chk("halt_done", 32'(done), 1);
        chk("halt_valid", 32'(addr_valid), 0);
        chk("halt_addr", 32'(out_addr_ROM), 15);
        en = 0;
        step("halt_en0");
        en = 1;
        step("halt_en1");
        load = 1; load_addr = 3;
        step("load3");
        chk("load3_addr", 32'(out_addr_ROM), 3);
        chk("load3_done", 32'(done), 0);
        chk("load3_valid", 32'(addr_valid), 1);
        load = 0; wrap = 1;
        for (int i = 0; i < 20 && m_addr != 6; i++) step("to6");
        chk("reach6", 32'(out_addr_ROM), 6);
        addr_ready = 0;
        repeat (5) step("stall");
        chk("stall_addr", 32'(out_addr_ROM), 6);
        chk("stall_valid", 32'(addr_valid), 1);
        addr_ready = 1;
        step("release");
        chk("release_addr", 32'(out_addr_ROM), 7);
        load = 1; load_addr = 2;
        step("load2");
        load_addr = 9; call = 1;
        step("call9");
        chk("call9_addr", 32'(out_addr_ROM), 9);
        load = 0; call = 0; ret = 1;
        step("ret");
        chk("ret_addr", 32'(out_addr_ROM), CALL_EN ? 3 : 10);
        ret = 0;
        for (int i = 0; i < 20 && m_addr != 11; i++) step("to11");
        chk("reach11", 32'(out_addr_ROM), 11);
        async_reset("midrun_rst");
        chk("midrun_rst_addr", 32'(out_addr_ROM), 0);
`ifdef ROM_SEQ_CALL_EN
        step("nest_start");
        for (int i = 0; i < 5; i++) begin
            load = 1; call = 1; load_addr = 4'(2 * i + 4);
            step("nest_call");
            if (i == 3) chk("nest_full", 32'(stk_full), 1);
        end
        chk("nest_err", 32'(stk_err), 1);
        chk("nest_addr_held", 32'(out_addr_ROM), 10);
        load = 0; call = 0;
        async_reset("nest_rst");
        step("empty_start");
        ret = 1;
        step("empty_ret");
        chk("empty_err", 32'(stk_err), 1);
        ret = 0;
`endif
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 9) != 0;
            wrap = 1'($urandom_range(0, 1));
            load = $urandom_range(0, 7) == 0;
            load_addr = 4'($urandom);
            addr_ready = $urandom_range(0, 3) != 0;
            call = 1'($urandom_range(0, 1));
            ret = $urandom_range(0, 3) == 0;
            step("rand");
            if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
